// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions used by the memory stage:
// datapath width, load/store funct3 encodings, access sizes and M-stage FSM states.
package rv32i_pkg;

    localparam int DPW = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} access_size_t;

    // Stores only define SB/SH/SW, loads also define LBU/LHU; any other
    // encoding falls back to a full word access.
    function automatic access_size_t access_size(input logic [2:0] f3, input logic is_store);
        if (is_store) begin
            case (f3)
                F3_SB:   return SZ_B;
                F3_SH:   return SZ_H;
                F3_SW:   return SZ_W;
                default: return SZ_W;
            endcase
        end
        case (f3)
            F3_LB, F3_LBU: return SZ_B;
            F3_LH, F3_LHU: return SZ_H;
            F3_LW:         return SZ_W;
            default:       return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for data memory accesses: byte enables and
// replicated store data, load byte/half extraction with sign or zero
// extension, and misalignment detection.
module mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]     funct3,
    input  logic           is_store,
    input  logic [1:0]     offset,
    input  logic [DPW-1:0] store_data,
    input  logic [DPW-1:0] read_data,
    output logic [3:0]     byte_en,
    output logic [DPW-1:0] write_data,
    output logic [DPW-1:0] load_data,
    output logic           misalign
);

    access_size_t size;
    logic         sign_ext;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;

    assign size      = access_size(funct3, is_store);
    assign sign_ext  = !is_store && !funct3[2];
    assign lane_byte = read_data[{offset, 3'b000} +: 8];
    assign lane_half = read_data[{offset[1], 4'b0000} +: 16];

    // Select lanes by access size; word accesses pass data straight through.
    always_comb begin
        byte_en    = 4'b1111;
        write_data = store_data;
        load_data  = read_data;
        misalign   = 1'b0;
        case (size)
            SZ_B: begin
                byte_en    = 4'b0001 << offset;
                write_data = {4{store_data[7:0]}};
                load_data  = sign_ext ? {{24{lane_byte[7]}}, lane_byte} : {24'b0, lane_byte};
            end
            SZ_H: begin
                byte_en    = 4'b0011 << offset;
                write_data = {2{store_data[15:0]}};
                load_data  = sign_ext ? {{16{lane_half[15]}}, lane_half} : {16'b0, lane_half};
                misalign   = offset[0];
            end
            default: begin
                misalign   = (offset != 2'b00);
            end
        endcase
        if (!is_store) begin
            write_data = '0;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: issues loads/stores over a req/ready handshake, stalls
// upstream while memory is busy and registers results into the M->W register.
module memory_stage
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           validM,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [2:0]     funct3M,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [4:0]     RdM,
    output logic           stallM,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [3:0]     dmem_be,
    output logic [DPW-1:0] dmem_wdata,
    input  logic           dmem_ready,
    input  logic [DPW-1:0] dmem_rdata,
    output logic           validW,
    output logic           regwriteW,
    output logic           resultsrcW,
    output logic [DPW-1:0] aluresultW,
    output logic [DPW-1:0] readdataW,
    output logic [4:0]     RdW,
    output logic           misalignW
);

    mem_state_t     state;
    mem_state_t     state_next;
    logic           memop;
    logic           misalign_raw;
    logic           misalign;
    logic           aligned_memop;
    logic           is_load;
    logic [DPW-1:0] load_data;

    mem_align u_align (
        .funct3     (funct3M),
        .is_store   (memwriteM),
        .offset     (aluresultM[1:0]),
        .store_data (Rd2M),
        .read_data  (dmem_rdata),
        .byte_en    (dmem_be),
        .write_data (dmem_wdata),
        .load_data  (load_data),
        .misalign   (misalign_raw)
    );

    assign memop         = validM & (resultsrcM | memwriteM);
    assign misalign      = memop & misalign_raw;
    assign aligned_memop = memop & !misalign_raw;
    assign is_load       = aligned_memop & !memwriteM;
    assign stallM        = dmem_req & !dmem_ready;
    assign dmem_we       = dmem_req & memwriteM;
    assign dmem_addr     = {aluresultM[DPW-1:2], 2'b00};

    // Handshake state register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request: the request is held until memory reports ready.
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        case (state)
            MS_IDLE: begin
                dmem_req = aligned_memop;
                if (aligned_memop && !dmem_ready) begin
                    state_next = MS_WAIT;
                end
            end
            MS_WAIT: begin
                dmem_req = aligned_memop;
                if (dmem_ready) begin
                    state_next = MS_IDLE;
                end
            end
        endcase
        if (rst) begin
            dmem_req = 1'b0;
        end
    end

    // M->W register: capture the instruction when not stalled, else insert a bubble.
    always_ff @(posedge clk) begin
        if (rst || stallM) begin
            validW     <= 1'b0;
            regwriteW  <= 1'b0;
            resultsrcW <= 1'b0;
            aluresultW <= '0;
            readdataW  <= '0;
            RdW        <= '0;
            misalignW  <= 1'b0;
        end else begin
            validW     <= validM;
            regwriteW  <= regwriteM & !misalign;
            resultsrcW <= resultsrcM;
            aluresultW <= aluresultM;
            readdataW  <= is_load ? load_data : '0;
            RdW        <= RdM;
            misalignW  <= misalign;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases with literal
// expectations, then randomized instructions and memory latencies checked
// against a byte-level behavioural model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, regwriteM, resultsrcM, memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluresultM, Rd2M;
    logic [4:0]  RdM;
    logic        stallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        validW, regwriteW, resultsrcW, misalignW;
    logic [31:0] aluresultW, readdataW;
    logic [4:0]  RdW;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        resultsrc;
        logic        misalign;
        logic        chk_data;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } wrec_t;

    wrec_t expq[$];
    wrec_t cur;
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .validM     (validM),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .funct3M    (funct3M),
        .aluresultM (aluresultM),
        .Rd2M       (Rd2M),
        .RdM        (RdM),
        .stallM     (stallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .validW     (validW),
        .regwriteW  (regwriteW),
        .resultsrcW (resultsrcW),
        .aluresultW (aluresultW),
        .readdataW  (readdataW),
        .RdW        (RdW),
        .misalignW  (misalignW)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Number of bytes touched; undefined encodings behave as a word access.
    function automatic int acc_bytes(input logic [2:0] f3, input logic st);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << off;
        return v[3:0];
    endfunction

    // Byte k of the bus carries byte (k mod size) of the store data.
    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int n, input int off, input bit sgn);
        longint v;
        v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Drives one instruction, holding it through the chosen number of wait
    // cycles, and queues the W-stage record expected after each edge.
    task automatic applyStimulus(input logic v, input logic rw, input logic rs, input logic mw,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d2,
                                 input logic [4:0] rd, input int lat, input logic [31:0] rdata);
        int    n, off;
        bit    memop, mis, alg, stall_exp;
        wrec_t r;
        n     = acc_bytes(f3, mw);
        off   = int'(addr[1:0]);
        memop = v && (rs || mw);
        mis   = memop && (off % n != 0);
        alg   = memop && !mis;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            validM     = v;
            regwriteM  = rw;
            resultsrcM = rs;
            memwriteM  = mw;
            funct3M    = f3;
            aluresultM = addr;
            Rd2M       = d2;
            RdM        = rd;
            dmem_ready = alg ? (c == lat) : 1'($urandom_range(0, 1));
            dmem_rdata = (alg && c == lat) ? rdata : $urandom;
            stall_exp  = alg && (c < lat);
            r = '0;
            if (!stall_exp) begin
                r.valid     = v;
                r.regwrite  = rw && !mis;
                r.resultsrc = rs;
                r.misalign  = mis;
                r.alu       = addr;
                r.rd        = rd;
                r.chk_data  = alg && !mw;
                r.rdata     = model_load(rdata, n, off, !mw && (f3 == 3'd0 || f3 == 3'd1));
            end else begin
                r.chk_data  = 1'b1;
            end
            expq.push_back(r);
            #1;
            checkOutput("dmem_req", dmem_req, alg);
            checkOutput("stallM", stallM, stall_exp);
            if (alg) begin
                checkOutput("dmem_we", dmem_we, mw);
                checkOutput("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                checkOutput("dmem_be", dmem_be, model_be(n, off));
                checkOutput("dmem_wdata", dmem_wdata, mw ? model_wdata(d2, n) : 32'h0);
            end
            if (!stall_exp) break;
        end
    endtask

    // Compare W-stage outputs against the model after every clock edge.
    always @(posedge clk) begin
        #2;
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            checkOutput("validW", validW, cur.valid);
            checkOutput("regwriteW", regwriteW, cur.regwrite);
            checkOutput("resultsrcW", resultsrcW, cur.resultsrc);
            checkOutput("misalignW", misalignW, cur.misalign);
            checkOutput("aluresultW", aluresultW, cur.alu);
            checkOutput("RdW", RdW, cur.rd);
            if (cur.chk_data) checkOutput("readdataW", readdataW, cur.rdata);
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        int          kind;

        rst = 1'b1;
        validM = 1'b1; regwriteM = 1'b1; resultsrcM = 1'b1; memwriteM = 1'b0;
        funct3M = 3'd2; aluresultM = 32'h40; Rd2M = '0; RdM = 5'd3;
        dmem_ready = 1'b1; dmem_rdata = 32'h1;

        // Reset holds W empty and suppresses the request.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_validW", validW, 0);
        checkOutput("rst_regwriteW", regwriteW, 0);
        checkOutput("rst_resultsrcW", resultsrcW, 0);
        checkOutput("rst_misalignW", misalignW, 0);
        checkOutput("rst_aluresultW", aluresultW, 0);
        checkOutput("rst_readdataW", readdataW, 0);
        checkOutput("rst_RdW", RdW, 0);
        checkOutput("rst_dmem_req", dmem_req, 0);
        rst = 1'b0;

        // ALU op passes to W in one cycle.
        applyStimulus(1, 1, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        @(posedge clk); #2;
        checkOutput("alu_validW", validW, 1);
        checkOutput("alu_aluresultW", aluresultW, 32'h1234);
        checkOutput("alu_RdW", RdW, 5);

        // SB to the top lane with zero-wait memory.
        applyStimulus(1, 0, 0, 1, 3'd0, 32'h103, 32'hAB, 5'd0, 0, 32'h0);
        checkOutput("sb_be", dmem_be, 4'b1000);
        checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
        checkOutput("sb_we", dmem_we, 1);
        checkOutput("sb_stall", stallM, 0);

        // LB / LBU with three wait cycles.
        applyStimulus(1, 1, 1, 0, 3'd0, 32'h102, 32'h0, 5'd7, 3, 32'h0080_0000);
        @(posedge clk); #2;
        checkOutput("lb_readdataW", readdataW, 32'hFFFFFF80);
        applyStimulus(1, 1, 1, 0, 3'd4, 32'h102, 32'h0, 5'd7, 3, 32'h0080_0000);
        @(posedge clk); #2;
        checkOutput("lbu_readdataW", readdataW, 32'h00000080);

        // Misaligned LW: no request, faults in W.
        applyStimulus(1, 1, 1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 0, 32'h0);
        checkOutput("mis_req", dmem_req, 0);
        checkOutput("mis_stall", stallM, 0);
        @(posedge clk); #2;
        checkOutput("mis_misalignW", misalignW, 1);
        checkOutput("mis_regwriteW", regwriteW, 0);

        // Reset while waiting on memory drops the request.
        @(negedge clk);
        validM = 1; regwriteM = 1; resultsrcM = 1; memwriteM = 0;
        funct3M = 3'd2; aluresultM = 32'h200; RdM = 5'd4; dmem_ready = 0;
        #1;
        checkOutput("wait_req", dmem_req, 1);
        checkOutput("wait_stall", stallM, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("rstwait_req", dmem_req, 0);
        checkOutput("rstwait_validW", validW, 0);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 0, 3'd2, 32'h40, 32'h0, 5'd6, 0, 32'hDEADBEEF);
        @(posedge clk); #2;
        checkOutput("fresh_lw_readdataW", readdataW, 32'hDEADBEEF);

        // Back-to-back LH then SW, both zero-wait.
        applyStimulus(1, 1, 1, 0, 3'd1, 32'h2, 32'h0, 5'd10, 0, 32'h8001_1234);
        checkOutput("lh_be", dmem_be, 4'b1100);
        applyStimulus(1, 0, 0, 1, 3'd2, 32'h8, 32'hCAFEF00D, 5'd0, 0, 32'h0);
        checkOutput("sw_be", dmem_be, 4'b1111);

        // Randomized mix of ALU ops, loads, stores and bubbles.
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 4));
            a    = $urandom;
            d    = $urandom;
            f    = 3'($urandom_range(0, 7));
            case (kind)
                0:       applyStimulus(1, 1'($urandom_range(0, 1)), 0, 0, f, a, d, 5'($urandom), 0, $urandom);
                2:       applyStimulus(1, 0, 0, 1, f, a, d, 5'($urandom), int'($urandom_range(0, 3)), $urandom);
                3:       applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       f, a, d, 5'($urandom), 0, $urandom);
                default: applyStimulus(1, 1, 1, 0, f, a, d, 5'($urandom), int'($urandom_range(0, 3)), $urandom);
            endcase
        end

        @(posedge clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
